mem2mem_xfer: RTL



---
 rtl/mem2mem_xfer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem2mem_xfer.sv
// mem2mem_xfer: memory-to-memory transfer engine.
//   Fills memory A from a streamed input, copies every word into memory B through a
//   per-word transform (copy / negate / difference / saturating sum), then streams
//   memory B out over a valid/ready handshake and pulses Done when the last word leaves.
// Ports:
//   clock, Reset        single clock, synchronous active-high reset
//   DataInA, InValid    input stream; written while InReady (FILL) is high
//   InReady             high in FILL
//   Mode                transform select, captured when the last input word lands
//   DataOutB, OutValid  output stream from memory B (DRAIN)
//   OutReady            downstream accept
//   Busy                high in XFER or DRAIN
//   Done                one-cycle pulse after the final DRAIN handshake
module mem2mem_xfer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DataInA,
  input  logic              InValid,
  output logic              InReady,
  input  logic [1:0]        Mode,
  output logic [DATA_W-1:0] DataOutB,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {StFill, StXfer, StDrain} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] wp_q, xp_q, rp_q;
  logic [1:0]        mode_q;
  logic              in_ready_q, out_valid_q, busy_q, done_q;

  // Memory contents survive reset; only pointers and control are cleared.
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  logic [DATA_W-1:0] prev_word;
  logic [DATA_W-1:0] xfer_word;

  function automatic logic [DATA_W-1:0] xform(input logic [1:0]        m,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] p);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] r;
    sum = {1'b0, a} + {1'b0, p};
    r   = a;
    case (m)
      2'b00:   r = a;
      2'b01:   r = (~a) + DATA_W'(1);
      2'b10:   r = a - p;
      default: r = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    endcase
    return r;
  endfunction

  always_comb begin
    prev_word = (xp_q == '0) ? '0 : mem_a[xp_q - ADDR_W'(1)];
    xfer_word = xform(mode_q, mem_a[xp_q], prev_word);
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q     <= StFill;
      wp_q        <= '0;
      xp_q        <= '0;
      rp_q        <= '0;
      mode_q      <= 2'b00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StFill: begin
          if (InValid) begin
            mem_a[wp_q] <= DataInA;
            wp_q        <= wp_q + ADDR_W'(1);  // wraps to 0 after the last word
            if (wp_q == LastAddr) begin
              mode_q     <= Mode;
              state_q    <= StXfer;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        StXfer: begin
          mem_b[xp_q] <= xfer_word;
          xp_q        <= xp_q + ADDR_W'(1);
          if (xp_q == LastAddr) begin
            state_q     <= StDrain;
            out_valid_q <= 1'b1;
          end
        end
        StDrain: begin
          if (OutReady) begin
            rp_q <= rp_q + ADDR_W'(1);
            if (rp_q == LastAddr) begin
              state_q     <= StFill;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              done_q      <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= StFill;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign DataOutB = mem_b[rp_q];

endmodule
